// File: rtl/bus_pkg.sv
// Shared types and constants for the system-bus arbiter.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Read data returned to a master whose transaction was ended by the watchdog.
    localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first requester after ptr, wrapping modulo N.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    int             offset;
    int             sum;

    // Rotate so that bit 0 is master ptr+1, find the lowest set bit, then map back.
    always_comb begin
        doubled = {req, req} >> (int'(ptr) + 1);
        rotated = doubled[N-1:0];
        offset  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = k;
            end
        end
        sum = int'(ptr) + 1 + offset;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = $clog2(N)'(sum);
        any = |req;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin N-master to 1-slave arbiter for the valid/ready memory bus, with a
// watchdog that force-completes transactions the slave never answers.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MASTER_COUNT = 2,
    parameter int TIMEOUT      = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MASTER_COUNT-1:0]          m_valid,
    input  logic [MASTER_COUNT-1:0]          m_instr,
    input  logic [MASTER_COUNT*ADDR_W-1:0]   m_addr,
    input  logic [MASTER_COUNT*DATA_W-1:0]   m_wdata,
    input  logic [MASTER_COUNT*STRB_W-1:0]   m_wstrb,
    output logic [MASTER_COUNT-1:0]          m_ready,
    output logic [DATA_W-1:0]                m_rdata,
    output logic                             s_valid,
    output logic                             s_instr,
    output logic [ADDR_W-1:0]                s_addr,
    output logic [DATA_W-1:0]                s_wdata,
    output logic [STRB_W-1:0]                s_wstrb,
    input  logic                             s_ready,
    input  logic [DATA_W-1:0]                s_rdata,
    output logic [$clog2(MASTER_COUNT)-1:0]  grant_id,
    output logic                             timeout_err
);

    // Handshake: a master raises m_valid with stable instr/addr/wdata/wstrb and holds
    // them until its one-cycle m_ready pulse; the slave side completes a BUSY cycle by
    // raising s_ready, which is looked at only while BUSY.

    localparam int IW = $clog2(MASTER_COUNT);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_e    state;
    arb_state_e    state_next;
    logic [IW-1:0] grant;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          complete;

    rr_picker #(
        .N(MASTER_COUNT)
    ) u_picker (
        .req(m_valid),
        .ptr(ptr),
        .any(pick_any),
        .idx(pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= IW'(MASTER_COUNT - 1);
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (complete) begin
                        ptr <= grant;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        complete    = 1'b0;
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m_ready     = '0;
        m_rdata     = '0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                s_valid = 1'b1;
                s_instr = m_instr[grant];
                s_addr  = m_addr[ADDR_W*int'(grant) +: ADDR_W];
                s_wdata = m_wdata[DATA_W*int'(grant) +: DATA_W];
                s_wstrb = m_wstrb[STRB_W*int'(grant) +: STRB_W];
                // A real completion in the watchdog's last cycle still wins.
                if (s_ready) begin
                    complete       = 1'b1;
                    m_ready[grant] = 1'b1;
                    m_rdata        = s_rdata;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    complete       = 1'b1;
                    m_ready[grant] = 1'b1;
                    m_rdata        = ERR_RDATA;
                    timeout_err    = 1'b1;
                end
                if (complete) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_id = grant;

endmodule
